// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - ROM fetch, instruction delivery and redirect signals of the prefetch unit
// Signal suffixes are from the prefetch unit's point of view (master).
interface if_prefetch_if;
  logic [31:0] rom_addr_o;
  logic        rom_req_o;
  logic [31:0] rom_inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output rom_addr_o, rom_req_o, inst_o, inst_pc_o, inst_valid_o,
    input  rom_inst_i, inst_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  rom_addr_o, rom_req_o, inst_o, inst_pc_o, inst_valid_o,
    output rom_inst_i, inst_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch: one-deep ROM pipeline feeding a DEPTH-entry FIFO
// Requests are throttled so buffered plus in-flight words never exceed DEPTH.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              OW      = PW + 1;
  localparam logic [OW:0]     DEPTH_W = (OW + 1)'(DEPTH);
  localparam logic [31:0]     PC_MASK = 32'hFFFF_FFFC;

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic          pop;
  logic          push;
  logic          req;
  logic [OW:0]   pending;

  always_comb begin
    pop     = (occ_q != '0) && bus.inst_ready_i;
    // A response is discarded if a redirect lands on its return cycle or one was pending.
    push    = inflight_q && !kill_q && !bus.redirect_i;
    pending = {1'b0, occ_q} + (OW + 1)'(inflight_q) - (OW + 1)'(pop);
    req     = !rst && !bus.redirect_i && (pending < DEPTH_W);

    fpc_d      = fpc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    kill_d     = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;

    if (bus.redirect_i) begin
      fpc_d      = bus.redirect_pc_i & PC_MASK;
      inflight_d = 1'b0;
      kill_d     = 1'b1;
      head_d     = '0;
      tail_d     = '0;
      occ_d      = '0;
    end else begin
      if (req) begin
        req_pc_d = fpc_q;
        fpc_d    = fpc_q + 32'd4;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC & PC_MASK;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      fpc_q      <= fpc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      if (push) begin
        inst_mem_q[tail_q] <= bus.rom_inst_i;
        pc_mem_q[tail_q]   <= req_pc_q;
      end
    end
  end

  assign bus.rom_addr_o   = fpc_q;
  assign bus.rom_req_o    = req;
  assign bus.inst_o       = inst_mem_q[head_q];
  assign bus.inst_pc_o    = pc_mem_q[head_q];
  assign bus.inst_valid_o = (occ_q != '0);
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries; legal values 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rom_addr_o  output  32  fetch byte address to ROM.
REQ-006 rom_req_o  output  1  fetch issued this cycle.
REQ-007 rom_inst_i  input  32  ROM read data, valid exactly one cycle after the rom_req_o cycle.
REQ-008 inst_o  output  32  instruction at buffer head.
REQ-009 inst_pc_o  output  32  PC of inst_o.
REQ-010 inst_valid_o  output  1  buffer head holds a valid instruction.
REQ-011 inst_ready_i  input  1  core accepts head; transfer occurs when inst_valid_o and inst_ready_i are both 1.
REQ-012 redirect_i  input  1  branch/jump taken in core; flush and refetch.
REQ-013 redirect_pc_i  input  32  new fetch address.

Function
REQ-014 A fetch PC register (fpc) SHALL drive rom_addr_o combinationally; fpc[1:0] SHALL always be 2'b00.
REQ-015 rom_req_o SHALL be 1 when (occupancy + in-flight − pop_this_cycle) < DEPTH and redirect_i is 0; on each issued request, fpc SHALL increment by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-016 At most one request SHALL be in flight; the in-flight flag SHALL set on issue and clear on the following cycle.
REQ-017 The returning rom_inst_i SHALL be written to the buffer tail together with the PC captured at issue, one cycle after the request.
REQ-018 The buffer SHALL be a circular FIFO of DEPTH entries with head/tail pointers and occupancy counter; it SHALL never overflow, guaranteed by REQ-015.
REQ-019 Simultaneous write and pop SHALL keep occupancy unchanged; pop from empty SHALL not occur since inst_valid_o=0.
REQ-020 Buffer SHALL NOT bypass: a returning instruction becomes visible on inst_o the cycle after it is written (total fetch-to-core latency 2 cycles).
REQ-021 inst_o/inst_pc_o SHALL hold stable while inst_valid_o=1 and inst_ready_i=0.
REQ-022 On redirect_i=1: buffer SHALL be emptied next cycle, fpc <= {redirect_pc_i[31:2],2'b00}, any in-flight response SHALL be discarded (kill flag), no request issued that cycle; first new request the following cycle.
REQ-023 redirect_i has priority over a simultaneous pop and a simultaneous response write; inst_valid_o SHALL be 0 the cycle after redirect.
REQ-024 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-025 Occupancy SHALL be DEPTH-wide+1 bits; inst_valid_o = (occupancy != 0).

Reset
REQ-026 While rst=1: fpc <= RESET_PC, occupancy/pointers <= 0, in-flight and kill <= 0, rom_req_o = 0, inst_valid_o = 0.
REQ-027 inst_o and inst_pc_o SHALL read 32'h0 after reset until first write.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; first request is issued the first cycle rst=0, at RESET_PC.

Verification
REQ-029 Reset release, ready=1, ROM returns addr-tagged data -> requests at 0x0,0x4,0x8...; inst_valid_o first 1 in cycle 2 after release with inst_pc_o=0x0, then one instruction per cycle in order.
REQ-030 ready held 0 for 10 cycles -> exactly DEPTH entries buffered, rom_req_o stays 0, inst_o frozen at PC 0x0; on ready=1 stream resumes without loss or duplication.
REQ-031 redirect_i=1, redirect_pc_i=0x0000_0103 while a request is in flight -> in-flight data dropped, next cycle inst_valid_o=0, next request at 0x0000_0100, first delivered inst_pc_o=0x100.
REQ-032 redirect on consecutive cycles to 0x200 then 0x300 -> only 0x300 stream delivered.
REQ-033 redirect to 0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 rst pulsed 1 cycle with buffer full -> inst_valid_o=0 next cycle, refetch from RESET_PC; scoreboard sees no stale instruction.
